// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS datapath and its control FSM.
package mc_pkg;

  localparam logic [5:0] A_ADD    = 6'b100000;
  localparam logic [5:0] A_SUB    = 6'b100010;
  localparam logic [5:0] A_AND    = 6'b100100;
  localparam logic [5:0] A_OR     = 6'b100101;
  localparam logic [5:0] A_XOR    = 6'b100110;
  localparam logic [5:0] A_NOR    = 6'b100111;
  localparam logic [5:0] IS_POSIT = 6'b111111;

  typedef enum logic [1:0] {
    SRCB_REG     = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } srcb_e;

  localparam logic [5:0] LW     = 6'b100011;
  localparam logic [5:0] SW     = 6'b101011;
  localparam logic [5:0] R_type = 6'b000000;
  localparam logic [5:0] BEQ    = 6'b000100;
  localparam logic [5:0] ADDI   = 6'b001000;

endpackage

// File: rtl/reg_file.sv
// 32-entry register file: two combinational read ports, one synchronous write
// port, register 0 hardwired to zero.
module reg_file #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [4:0]       ra1_i,
  input  logic [4:0]       ra2_i,
  input  logic [4:0]       wa_i,
  input  logic [WIDTH-1:0] wd_i,
  output logic [WIDTH-1:0] rd1_o,
  output logic [WIDTH-1:0] rd2_o
);

  logic [WIDTH-1:0] regs_q [32];

  // NOTE: the whole array is reset on purpose -- a reset mid-program must
  // leave every architectural register at zero, so this cannot map to a RAM.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we_i && (wa_i != 5'd0)) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  // No write-to-read bypass: a same-cycle read returns the pre-edge value.
  assign rd1_o = (ra1_i == 5'd0) ? '0 : regs_q[ra1_i];
  assign rd2_o = (ra2_i == 5'd0) ? '0 : regs_q[ra2_i];

endmodule

// File: rtl/mc_datapath.sv
// Multicycle MIPS datapath: PC, IR, register file, A/B/MDR/ALUOut latches and
// the unified memory port, steered cycle by cycle by the control FSM.
module mc_datapath
  import mc_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] PC_RESET = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             PCWrite,
  input  logic             Branch,
  input  logic             PCSrc,
  input  logic [5:0]       ALUControl,
  input  logic [1:0]       ALUSrcB,
  input  logic             ALUSrcA,
  input  logic             RegWrite,
  input  logic             IorD,
  input  logic             MemWrite,
  input  logic             IRWrite,
  input  logic             RegDst,
  input  logic             MemtoReg,
  output logic [5:0]       Op,
  output logic [5:0]       Funct,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_we,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [WIDTH-1:0] pc
);

  logic [WIDTH-1:0] pc_q, pc_d, ir_q, a_q, b_q, mdr_q, aluout_q;
  logic [WIDTH-1:0] rd1, rd2, src_a, src_b, alu_result, imm_ext, rf_wd;
  logic [4:0]       rf_wa;
  logic             zero, pc_en;

  reg_file #(.WIDTH(WIDTH)) u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .we_i  (RegWrite),
    .ra1_i (ir_q[25:21]),
    .ra2_i (ir_q[20:16]),
    .wa_i  (rf_wa),
    .wd_i  (rf_wd),
    .rd1_o (rd1),
    .rd2_o (rd2)
  );

  assign imm_ext = {{(WIDTH-16){ir_q[15]}}, ir_q[15:0]};
  assign rf_wa   = RegDst ? ir_q[15:11] : ir_q[20:16];
  assign rf_wd   = MemtoReg ? mdr_q : aluout_q;
  assign src_a   = ALUSrcA ? a_q : pc_q;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    src_b = b_q;
    case (srcb_e'(ALUSrcB))
      SRCB_REG:     src_b = b_q;
      SRCB_FOUR:    src_b = WIDTH'(4);
      SRCB_IMM:     src_b = imm_ext;
      SRCB_IMM_SH2: src_b = {imm_ext[WIDTH-3:0], 2'b00};
      default:      src_b = b_q;
    endcase
  end

  always_comb begin
    alu_result = '0;
    case (ALUControl)
      A_ADD:            alu_result = src_a + src_b;
      A_SUB, IS_POSIT:  alu_result = src_a - src_b;
      A_AND:            alu_result = src_a & src_b;
      A_OR:             alu_result = src_a | src_b;
      A_XOR:            alu_result = src_a ^ src_b;
      A_NOR:            alu_result = ~(src_a | src_b);
      default:          alu_result = '0;
    endcase
  end

  assign zero  = (alu_result == '0);
  assign pc_en = PCWrite | (Branch & zero);
  assign pc_d  = PCSrc ? aluout_q : alu_result;

  // A, B, MDR and ALUOut reload every cycle; only PC and IR are enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= PC_RESET;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mdr_q    <= '0;
      aluout_q <= '0;
    end else begin
      if (pc_en)   pc_q <= pc_d;
      if (IRWrite) ir_q <= mem_rdata;
      a_q      <= rd1;
      b_q      <= rd2;
      mdr_q    <= mem_rdata;
      aluout_q <= alu_result;
    end
  end

  assign Op        = ir_q[31:26];
  assign Funct     = ir_q[5:0];
  assign mem_addr  = IorD ? aluout_q : pc_q;
  assign mem_wdata = b_q;
  assign mem_we    = MemWrite;
  assign pc        = pc_q;

endmodule
